// File: rtl/m_clint_smp_if.sv
// ---------------------------------------------------------------------------
// m_clint_smp_if
//   MMIO request/response bundle between the memory controller (master) and
//   the CLINT (slave). Single-cycle requests, no back-pressure.
//
//   w_re      master -> slave  read request, one cycle
//   w_we      master -> slave  write request, one cycle
//   w_offset  master -> slave  byte offset in the CLINT window (bits[1:0] ignored)
//   w_wdata   master -> slave  write data
//   r_rdata   slave -> master  read data, valid while r_rvalid is high
//   r_rvalid  slave -> master  one-cycle pulse, one cycle after w_re
// ---------------------------------------------------------------------------
interface m_clint_smp_if;
    logic        w_re;
    logic        w_we;
    logic [15:0] w_offset;
    logic [31:0] w_wdata;
    logic [31:0] r_rdata;
    logic        r_rvalid;

    modport master (
        output w_re, w_we, w_offset, w_wdata,
        input  r_rdata, r_rvalid
    );

    modport slave (
        input  w_re, w_we, w_offset, w_wdata,
        output r_rdata, r_rvalid
    );
endinterface

// File: rtl/m_clint_smp.sv
// ---------------------------------------------------------------------------
// m_clint_smp
//   Core-local interruptor for the SMP cluster: the 64-bit mtime counter with
//   a programmable prescaler, one mtimecmp and one msip per hart, and a 32-bit
//   MMIO register window.
//
//   CLK       clock
//   RST_X     asynchronous active-low reset
//   bus       MMIO slave port (m_clint_smp_if.slave)
//   w_mtime   current mtime
//   w_mtip    per-hart machine timer pending, (mtime >= mtimecmp) registered
//   w_msip    per-hart machine software interrupt (msip bit0)
//
//   Map: 0x0000+4h msip[h], 0x4000+8h / 0x4004+8h mtimecmp[h] lo/hi,
//        0xBFF8 / 0xBFFC mtime lo/hi. Anything else reads 0, ignores writes.
// ---------------------------------------------------------------------------
module m_clint_smp #(
    parameter int N_HARTS  = 1,
    parameter int TICK_DIV = 1
) (
    input  logic                CLK,
    input  logic                RST_X,
    m_clint_smp_if.slave        bus,
    output logic [63:0]         w_mtime,
    output logic [N_HARTS-1:0]  w_mtip,
    output logic [N_HARTS-1:0]  w_msip
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [15:0] MSIP_BASE     = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] MTIME_LO      = 16'hBFF8;
    localparam logic [15:0] MTIME_HI      = 16'hBFFC;

    logic [PW-1:0]              presc_q, presc_d;
    logic [63:0]                mtime_q, mtime_d;
    logic [N_HARTS-1:0][63:0]   mtimecmp_q, mtimecmp_d;
    logic [N_HARTS-1:0]         msip_q, msip_d;
    logic [N_HARTS-1:0]         mtip_q, mtip_d;
    logic [31:0]                rdata_q, rdata_d;
    logic                       rvalid_q, rvalid_d;

    logic [15:0] addr;
    logic        tick;
    logic [31:0] rd_val;

    // Word access only: the byte-lane bits are masked off before decode.
    assign addr = bus.w_offset & 16'hFFFC;
    assign tick = (presc_q == PW'(TICK_DIV - 1));

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the block leaves it unassigned and infers a latch.
        presc_d    = tick ? '0 : presc_q + PW'(1);
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        mtip_d     = '0;
        rdata_d    = rdata_q;
        rvalid_d   = bus.w_re;
        rd_val     = '0;

        // A software write to either half wins over the tick; the increment
        // for that cycle is lost and the prescaler keeps running.
        if (bus.w_we && addr == MTIME_LO) begin
            mtime_d[31:0] = bus.w_wdata;
        end else if (bus.w_we && addr == MTIME_HI) begin
            mtime_d[63:32] = bus.w_wdata;
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        if (addr == MTIME_LO) rd_val = mtime_q[31:0];
        if (addr == MTIME_HI) rd_val = mtime_q[63:32];

        for (int h = 0; h < N_HARTS; h++) begin
            // Compare uses the current (pre-write, pre-increment) values, so
            // w_mtip lags any mtime/mtimecmp change by one cycle.
            mtip_d[h] = (mtime_q >= mtimecmp_q[h]);

            if (addr == MSIP_BASE + 16'(4 * h)) begin
                rd_val = {31'b0, msip_q[h]};
                if (bus.w_we) msip_d[h] = bus.w_wdata[0];
            end
            if (addr == MTIMECMP_BASE + 16'(8 * h)) begin
                rd_val = mtimecmp_q[h][31:0];
                if (bus.w_we) mtimecmp_d[h][31:0] = bus.w_wdata;
            end
            if (addr == MTIMECMP_BASE + 16'(8 * h + 4)) begin
                rd_val = mtimecmp_q[h][63:32];
                if (bus.w_we) mtimecmp_d[h][63:32] = bus.w_wdata;
            end
        end

        // Read data is sampled from the register state before this edge's
        // writes land, giving read-before-write on a same-cycle collision.
        if (bus.w_re) rdata_d = rd_val;
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            presc_q    <= '0;
            mtime_q    <= '0;
            // NOTE: mtimecmp is a flop bank, not RAM, so it can and must be
            // reset; all-ones keeps every timer interrupt quiet out of reset.
            mtimecmp_q <= '1;
            msip_q     <= '0;
            mtip_q     <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            // NOTE: state updates are non-blocking so every flop samples the
            // values from before this edge, independent of statement order.
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            mtip_q     <= mtip_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign w_mtime      = mtime_q;
    assign w_mtip       = mtip_q;
    assign w_msip       = msip_q;
    assign bus.r_rdata  = rdata_q;
    assign bus.r_rvalid = rvalid_q;

endmodule

// File: tb/tb_m_clint_smp.sv
// ---------------------------------------------------------------------------
// tb_m_clint_smp
//   Two CLINT instances share clock and reset:
//     dut_a: N_HARTS=2, TICK_DIV=1
//     dut_b: N_HARTS=1, TICK_DIV=4
//   A register-map-level model per instance is stepped on every clock edge
//   and compared against all outputs on every falling edge; directed
//   sequences add literal expectations at the interesting points.
// ---------------------------------------------------------------------------
module tb_m_clint_smp;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    m_clint_smp_if bus_a ();
    m_clint_smp_if bus_b ();

    logic [63:0] mtime_a, mtime_b;
    logic [1:0]  mtip_a, msip_a;
    logic [0:0]  mtip_b, msip_b;

    m_clint_smp #(.N_HARTS(2), .TICK_DIV(1)) dut_a (
        .CLK(clk), .RST_X(rst_n), .bus(bus_a),
        .w_mtime(mtime_a), .w_mtip(mtip_a), .w_msip(msip_a)
    );

    m_clint_smp #(.N_HARTS(1), .TICK_DIV(4)) dut_b (
        .CLK(clk), .RST_X(rst_n), .bus(bus_b),
        .w_mtime(mtime_b), .w_mtip(mtip_b), .w_msip(msip_b)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [63:0]      mtime;
        logic [31:0]      cyc;     // clock edges since reset released
        logic [1:0][63:0] cmp;
        logic [1:0]       msip;
        logic [1:0]       mtip;
        logic [31:0]      rdata;
        logic             rvalid;
    } model_t;

    function automatic model_t model_reset();
        model_t s;
        s.mtime  = '0;
        s.cyc    = '0;
        s.cmp    = {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        s.msip   = '0;
        s.mtip   = '0;
        s.rdata  = '0;
        s.rvalid = 1'b0;
        return s;
    endfunction

    function automatic logic [31:0] model_read(input model_t s, input int nh, input logic [15:0] a);
        logic [31:0] v = '0;
        if (a == 16'hBFF8) v = s.mtime[31:0];
        if (a == 16'hBFFC) v = s.mtime[63:32];
        for (int h = 0; h < nh; h++) begin
            if (a == 16'(4 * h))           v = {31'b0, s.msip[h]};
            if (a == 16'(16'h4000 + 8 * h)) v = s.cmp[h][31:0];
            if (a == 16'(16'h4004 + 8 * h)) v = s.cmp[h][63:32];
        end
        return v;
    endfunction

    function automatic model_t model_step(input model_t s, input int nh, input int td,
                                          input logic re, input logic we,
                                          input logic [15:0] off, input logic [31:0] wd);
        model_t      n = s;
        logic [15:0] a = {off[15:2], 2'b00};
        logic        tick = ((s.cyc % 32'(td)) == 32'(td - 1));
        n.cyc    = s.cyc + 1;
        n.rvalid = re;
        if (re) n.rdata = model_read(s, nh, a);
        if (we && a == 16'hBFF8)      n.mtime[31:0]  = wd;
        else if (we && a == 16'hBFFC) n.mtime[63:32] = wd;
        else if (tick)                n.mtime = s.mtime + 64'd1;
        for (int h = 0; h < 2; h++) begin
            n.mtip[h] = (h < nh) && (s.mtime >= s.cmp[h]);
            if (we && h < nh) begin
                if (a == 16'(4 * h))            n.msip[h] = wd[0];
                if (a == 16'(16'h4000 + 8 * h)) n.cmp[h][31:0]  = wd;
                if (a == 16'(16'h4004 + 8 * h)) n.cmp[h][63:32] = wd;
            end
        end
        return n;
    endfunction

    model_t ma, mb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= model_reset();
            mb <= model_reset();
        end else begin
            ma <= model_step(ma, 2, 1, bus_a.w_re, bus_a.w_we, bus_a.w_offset, bus_a.w_wdata);
            mb <= model_step(mb, 1, 4, bus_b.w_re, bus_b.w_we, bus_b.w_offset, bus_b.w_wdata);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("a_mtime",  mtime_a, ma.mtime);
            check("a_mtip",   64'(mtip_a), 64'(ma.mtip));
            check("a_msip",   64'(msip_a), 64'(ma.msip));
            check("a_rvalid", 64'(bus_a.r_rvalid), 64'(ma.rvalid));
            if (ma.rvalid) check("a_rdata", 64'(bus_a.r_rdata), 64'(ma.rdata));
            check("b_mtime",  mtime_b, mb.mtime);
            check("b_mtip",   64'(mtip_b), 64'(ma.mtip[0] & 1'b0 | mb.mtip[0]));
            check("b_msip",   64'(msip_b), 64'(mb.msip[0]));
            check("b_rvalid", 64'(bus_b.r_rvalid), 64'(mb.rvalid));
            if (mb.rvalid) check("b_rdata", 64'(bus_b.r_rdata), 64'(mb.rdata));
        end
    end

    // ---------------- bus tasks (call at a falling edge) ----------------
    task automatic bus_wr(input int k, input logic [15:0] off, input logic [31:0] d);
        if (k == 0) begin
            bus_a.w_we = 1'b1; bus_a.w_offset = off; bus_a.w_wdata = d;
        end else begin
            bus_b.w_we = 1'b1; bus_b.w_offset = off; bus_b.w_wdata = d;
        end
        @(negedge clk);
        bus_a.w_we = 1'b0;
        bus_b.w_we = 1'b0;
    endtask

    task automatic bus_rd(input int k, input logic [15:0] off);
        if (k == 0) begin
            bus_a.w_re = 1'b1; bus_a.w_offset = off;
        end else begin
            bus_b.w_re = 1'b1; bus_b.w_offset = off;
        end
        @(negedge clk);
        bus_a.w_re = 1'b0;
        bus_b.w_re = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic found;
        bus_a.w_re = 1'b0; bus_a.w_we = 1'b0; bus_a.w_offset = '0; bus_a.w_wdata = '0;
        bus_b.w_re = 1'b0; bus_b.w_we = 1'b0; bus_b.w_offset = '0; bus_b.w_wdata = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mtime_a",  mtime_a, 64'd0);
        check("rst_mtip_a",   64'(mtip_a), 64'd0);
        check("rst_msip_a",   64'(msip_a), 64'd0);
        check("rst_rvalid_a", 64'(bus_a.r_rvalid), 64'd0);
        check("rst_rdata_a",  64'(bus_a.r_rdata), 64'd0);
        check("rst_mtime_b",  mtime_b, 64'd0);
        chk_en = 1'b1;
        rst_n  = 1'b1;

        // 1: free-running count
        repeat (10) @(negedge clk);
        check("t1_mtime_a", mtime_a, 64'd10);
        check("t1_mtip_a",  64'(mtip_a), 64'd0);
        check("t1_msip_a",  64'(msip_a), 64'd0);
        check("t1_mtime_b", mtime_b, 64'd2);

        // 2: hart0 timer interrupt timing
        bus_wr(0, 16'h4000, 32'd5);
        bus_wr(0, 16'h4004, 32'd0);
        bus_wr(0, 16'hBFF8, 32'd0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mtime_a == 64'd5) found = 1'b1;
            else @(negedge clk);
        end
        check("t2_reach5", 64'(found), 64'd1);
        check("t2_mtip_at5", 64'(mtip_a[0]), 64'd0);
        @(negedge clk);
        check("t2_mtip_after5", 64'(mtip_a[0]), 64'd1);
        bus_wr(0, 16'h4000, 32'hFFFF_FFFF);
        check("t2_mtip_at_wr", 64'(mtip_a[0]), 64'd1);
        @(negedge clk);
        check("t2_mtip_clr", 64'(mtip_a[0]), 64'd0);

        // 3: msip for hart1, readback, same-cycle read/write
        bus_wr(0, 16'h0004, 32'd1);
        check("t3_msip_set", 64'(msip_a), 64'd2);
        bus_rd(0, 16'h0004);
        check("t3_rvalid", 64'(bus_a.r_rvalid), 64'd1);
        check("t3_rdata",  64'(bus_a.r_rdata), 64'd1);
        @(negedge clk);
        check("t3_rvalid_drop", 64'(bus_a.r_rvalid), 64'd0);
        bus_wr(0, 16'h0004, 32'd0);
        check("t3_msip_clr", 64'(msip_a), 64'd0);
        bus_a.w_re = 1'b1; bus_a.w_we = 1'b1; bus_a.w_offset = 16'h0000; bus_a.w_wdata = 32'd1;
        @(negedge clk);
        bus_a.w_re = 1'b0; bus_a.w_we = 1'b0;
        check("t3_rw_rdata", 64'(bus_a.r_rdata), 64'd0);
        check("t3_rw_msip",  64'(msip_a), 64'd1);

        // 4: carry into hi, wrap to zero
        bus_wr(0, 16'hBFF8, 32'hFFFF_FFFE);
        bus_wr(0, 16'hBFFC, 32'd0);
        check("t4_set", mtime_a, 64'h0000_0000_FFFF_FFFE);
        repeat (2) @(negedge clk);
        check("t4_carry", mtime_a, 64'h0000_0001_0000_0000);
        bus_wr(0, 16'hBFF8, 32'hFFFF_FFFF);
        bus_wr(0, 16'hBFFC, 32'hFFFF_FFFF);
        check("t4_ones", mtime_a, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        check("t4_wrap", mtime_a, 64'd0);

        // 5: TICK_DIV=4, mtime write in a tick cycle drops the increment
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if ((mb.cyc % 32'd4) == 32'd3) found = 1'b1;
            else @(negedge clk);
        end
        check("t5_tick_found", 64'(found), 64'd1);
        bus_wr(1, 16'hBFF8, 32'd100);
        check("t5_wr_in_tick", mtime_b, 64'd100);
        repeat (3) @(negedge clk);
        check("t5_hold", mtime_b, 64'd100);
        @(negedge clk);
        check("t5_next_tick", mtime_b, 64'd101);

        // 6: out-of-range and unmapped accesses, byte-lane bits
        bus_rd(0, 16'h4010);
        check("t6_oor_rvalid", 64'(bus_a.r_rvalid), 64'd1);
        check("t6_oor_rdata",  64'(bus_a.r_rdata), 64'd0);
        bus_wr(0, 16'h4010, 32'h1234);
        bus_rd(0, 16'h4010);
        check("t6_oor_after_wr", 64'(bus_a.r_rdata), 64'd0);
        bus_rd(0, 16'h400C);
        check("t6_cmp1_hi", 64'(bus_a.r_rdata), 64'hFFFF_FFFF);
        bus_rd(0, 16'h4003);
        check("t6_lane_bits", 64'(bus_a.r_rdata), 64'hFFFF_FFFF);
        bus_wr(1, 16'h0004, 32'd1);
        check("t6_b_msip_oor", 64'(msip_b), 64'd0);
        bus_rd(1, 16'h4008);
        check("t6_b_cmp_oor", 64'(bus_b.r_rdata), 64'd0);
        bus_rd(1, 16'h1000);
        check("t6_b_unmapped_rv", 64'(bus_b.r_rvalid), 64'd1);
        check("t6_b_unmapped",    64'(bus_b.r_rdata), 64'd0);

        // reset pulsed while a read is outstanding
        bus_a.w_re = 1'b1; bus_a.w_offset = 16'h4000;
        bus_b.w_re = 1'b1; bus_b.w_offset = 16'hBFF8;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t6_rst_rvalid_a", 64'(bus_a.r_rvalid), 64'd0);
        check("t6_rst_rvalid_b", 64'(bus_b.r_rvalid), 64'd0);
        check("t6_rst_mtime_a",  mtime_a, 64'd0);
        @(negedge clk);
        bus_a.w_re = 1'b0;
        bus_b.w_re = 1'b0;
        rst_n = 1'b1;
        bus_rd(0, 16'h4000);
        check("t6_rst_cmp_lo", 64'(bus_a.r_rdata), 64'hFFFF_FFFF);
        bus_rd(0, 16'h4004);
        check("t6_rst_cmp_hi", 64'(bus_a.r_rdata), 64'hFFFF_FFFF);
        check("t6_rst_msip", 64'(msip_a), 64'd0);

        repeat (4) @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
